// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration stream loader.
// Holds the controller state encoding and the helpers that size the
// word stream for a given chain length and word width.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Number of stream words needed to cover the whole chain.
  function automatic int num_words(input int config_width, input int word_width);
    return (config_width + word_width - 1) / word_width;
  endfunction

  // Bits actually used in the final (possibly partial) word.
  function automatic int last_word_bits(input int config_width, input int word_width);
    return ((config_width % word_width) == 0) ? word_width : (config_width % word_width);
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Phase timer for the configuration shift clock.
// Counts CLK_DIV cycles per config_clk phase and flags the last cycle of the
// current phase. Reloads whenever the phase ends or shifting is not running,
// so consecutive LO/HI phases chain without a dead cycle.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   run_i        high while the controller is in a shift phase
//   phase_last_o high on the final cycle of the current phase
module cfg_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic phase_last_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_last_o = (cnt_q == '0);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (!run_i || phase_last_o) cnt_d = RELOAD;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/config_stream_loader.sv
// Configuration stream loader.
// Load mode: takes bitstream words over valid/ready and shifts them, bit 0
// first, into the fabric chain via config_in/config_clk/config_en.
// Readback mode: shifts the chain with config_out fed back into config_in
// (leaving the contents intact) and returns the captured bits as words.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   start, mode            operation request (mode 0 = load, 1 = readback)
//   in_data/valid/ready    bitstream input stream
//   out_data/valid/ready   readback output stream
//   busy, done             status; done pulses one cycle at completion
//   config_in/clk/en       fabric shift chain drive
//   config_out             fabric chain tail
module config_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = 707,
  parameter int WORD_WIDTH   = 8,
  parameter int CLK_DIV      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  config_in,
  output logic                  config_clk,
  output logic                  config_en,
  input  logic                  config_out
);

  localparam int CNT_W = $clog2(CONFIG_WIDTH + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CONFIG_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  cfg_in_q, cfg_in_d;
  logic                  busy_q, done_q, in_ready_q, out_valid_q, cfg_clk_q, cfg_en_q;
  logic                  shifting, phase_last;

  assign shifting = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);

  cfg_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .clk          (clk),
    .rst          (rst),
    .run_i        (shifting),
    .phase_last_o (phase_last)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    cfg_in_d  = cfg_in_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        mode_d    = mode;
        word_d    = '0;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = mode ? ST_SHIFT_LO : ST_FETCH;
      end
      ST_FETCH: if (in_valid && in_ready_q) begin
        word_d    = in_data;
        bit_idx_d = '0;
        state_d   = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (phase_last) begin
        // The tail bit only moves on a config_clk rise, so it is stable here.
        if (mode_q) word_d[bit_idx_q] = config_out;
        state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: if (phase_last) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_d == LAST_BIT) begin
          state_d = mode_q ? ST_EMIT : ST_DONE;
        end else if (bit_idx_q == LAST_IDX) begin
          state_d = mode_q ? ST_EMIT : ST_FETCH;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_EMIT: if (out_ready) begin
        // Clearing here leaves unused bits of a final partial word at zero.
        word_d    = '0;
        bit_idx_d = '0;
        state_d   = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SHIFT_LO;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // config_in is chosen once per bit, on entry to SHIFT_LO, and then held.
    if ((state_d == ST_SHIFT_LO) && (state_q != ST_SHIFT_LO))
      cfg_in_d = mode_d ? config_out : word_d[bit_idx_d];
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      cfg_in_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_clk_q   <= 1'b0;
      cfg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      cfg_in_q    <= cfg_in_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      in_ready_q  <= (state_d == ST_FETCH);
      out_valid_q <= (state_d == ST_EMIT);
      cfg_clk_q   <= (state_d == ST_SHIFT_HI);
      cfg_en_q    <= (state_d inside {ST_FETCH, ST_SHIFT_LO, ST_SHIFT_HI, ST_EMIT});
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? word_q : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign config_in  = cfg_in_q;
  assign config_clk = cfg_clk_q;
  assign config_en  = cfg_en_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: two instances (CLK_DIV 2 and 1),
// each driving a behavioural model of the fabric shift chain.
module tb_config_stream_loader;
  import cfg_loader_pkg::*;

  localparam int CW  = 707;
  localparam int WW  = 8;
  localparam int NW  = num_words(CW, WW);
  localparam int TMO = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0, mode = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0;

  logic       in_ready0, out_valid0, busy0, done0, cfg_in0, cfg_clk0, cfg_en0, cfg_out0;
  logic       in_ready1, out_valid1, busy1, done1, cfg_in1, cfg_clk1, cfg_en1, cfg_out1;
  logic [7:0] out_data0, out_data1;

  config_stream_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .busy(busy0), .done(done0), .config_in(cfg_in0), .config_clk(cfg_clk0),
    .config_en(cfg_en0), .config_out(cfg_out0));

  config_stream_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .busy(busy1), .done(done1), .config_in(cfg_in1), .config_clk(cfg_clk1),
    .config_en(cfg_en1), .config_out(cfg_out1));

  // Signals of the instance currently under test.
  int         sel = 0;
  logic       in_ready, out_valid, busy, cfg_clk, cfg_en;
  logic [7:0] out_data;
  assign in_ready  = (sel == 1) ? in_ready1  : in_ready0;
  assign out_valid = (sel == 1) ? out_valid1 : out_valid0;
  assign busy      = (sel == 1) ? busy1      : busy0;
  assign cfg_clk   = (sel == 1) ? cfg_clk1   : cfg_clk0;
  assign cfg_en    = (sel == 1) ? cfg_en1    : cfg_en0;
  assign out_data  = (sel == 1) ? out_data1  : out_data0;

  // Fabric chain models: index CW-1 is the head, index 0 the tail, so after a
  // full load chain[k] holds stream bit k.
  logic chain0 [CW];
  logic chain1 [CW];
  assign cfg_out0 = chain0[0];
  assign cfg_out1 = chain1[0];

  int  edges0 = 0, edges1 = 0, sp_bit0 = 0, sp_word0 = 0, sp_bit1 = 0, sp_word1 = 0;
  int  done_cnt0 = 0, done_cnt1 = 0;
  time last0 = 0, last1 = 0;

  always @(posedge cfg_clk0) if (cfg_en0) begin
    for (int i = 0; i < CW - 1; i++) chain0[i] <= chain0[i+1];
    chain0[CW-1] <= cfg_in0;
    edges0 <= edges0 + 1;
    if ($time - last0 == 40)      sp_bit0  <= sp_bit0 + 1;
    else if ($time - last0 == 50) sp_word0 <= sp_word0 + 1;
    last0 <= $time;
  end

  always @(posedge cfg_clk1) if (cfg_en1) begin
    for (int i = 0; i < CW - 1; i++) chain1[i] <= chain1[i+1];
    chain1[CW-1] <= cfg_in1;
    edges1 <= edges1 + 1;
    if ($time - last1 == 20)      sp_bit1  <= sp_bit1 + 1;
    else if ($time - last1 == 30) sp_word1 <= sp_word1 + 1;
    last1 <= $time;
  end

  always @(posedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] tx_words [NW];
  logic [7:0] rx_words [NW];

  function automatic int chain_errs(input int s);
    int   n;
    logic exp_b, got_b;
    n = 0;
    for (int k = 0; k < CW; k++) begin
      exp_b = tx_words[k / WW][k % WW];
      got_b = (s == 1) ? chain1[k] : chain0[k];
      if (got_b !== exp_b) n++;
    end
    return n;
  endfunction

  task automatic pulse_start(input int s, input logic m);
    sel  = s;
    mode = m;
    if (s == 1) start1 = 1'b1;
    else        start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Streams tx_words; with gaps set, every 3rd word is held back 7 cycles
  // after the loader starts asking for it.
  task automatic send_words(input bit gaps, output int gap_viol, output int gap_cnt);
    int wt;
    gap_viol = 0;
    gap_cnt  = 0;
    for (int k = 0; k < NW; k++) begin
      if (gaps && (k % 3 == 2)) begin
        in_valid = 1'b0;
        wt = 0;
        while (!in_ready && wt < TMO) begin @(negedge clk); wt++; end
        gap_cnt++;
        repeat (7) begin
          if (cfg_clk !== 1'b0 || cfg_en !== 1'b1) gap_viol++;
          @(negedge clk);
        end
      end
      in_data  = tx_words[k];
      in_valid = 1'b1;
      wt = 0;
      while (!in_ready && wt < TMO) begin @(negedge clk); wt++; end
      if (!in_ready) begin
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int wt;
    wt = 0;
    while (busy && wt < 4 * TMO) begin @(negedge clk); wt++; end
    if (busy) check(tag, 32'(busy), 32'd0);
  endtask

  task automatic readback(input int s, output int n_rx, output int bp_viol);
    logic tog;
    int   wt;
    tog = 1'b1;
    wt  = 0;
    n_rx = 0;
    bp_viol = 0;
    pulse_start(s, 1'b1);
    mode = 1'b0;
    while (n_rx < NW && wt < 20000) begin
      out_ready = tog;
      tog = ~tog;
      if (out_valid && out_ready) begin
        rx_words[n_rx] = out_data;
        n_rx++;
      end else if (out_valid && cfg_clk) begin
        bp_viol++;
      end
      @(negedge clk);
      wt++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e0, d0, s4, s5, gv, gc, nrx, bpv, errs, wt;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy0),      32'd0);
    check("rst_done",      32'(done0),      32'd0);
    check("rst_in_ready",  32'(in_ready0),  32'd0);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_data",  32'(out_data0),  32'd0);
    check("rst_cfg_en",    32'(cfg_en0),    32'd0);
    check("rst_cfg_clk",   32'(cfg_clk0),   32'd0);
    check("rst_cfg_in",    32'(cfg_in0),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Gapless 0xA5 load.
    for (int k = 0; k < NW; k++) tx_words[k] = 8'hA5;
    e0 = edges0; d0 = done_cnt0; s4 = sp_bit0; s5 = sp_word0;
    pulse_start(0, 1'b0);
    send_words(1'b0, gv, gc);
    wait_idle("a5_idle");
    check("a5_edges",   32'(edges0 - e0),    32'd707);
    check("a5_done",    32'(done_cnt0 - d0), 32'd1);
    check("a5_chain",   32'(chain_errs(0)),  32'd0);
    check("a5_sp_bit",  32'(sp_bit0 - s4),   32'd618);
    check("a5_sp_word", 32'(sp_word0 - s5),  32'd88);
    check("a5_en_low",  32'(cfg_en0),        32'd0);

    // Load with in_valid gaps.
    for (int k = 0; k < NW; k++) tx_words[k] = 8'(k * 37 + 11);
    e0 = edges0; d0 = done_cnt0;
    pulse_start(0, 1'b0);
    send_words(1'b1, gv, gc);
    wait_idle("gap_idle");
    check("gap_count", 32'(gc),              32'd29);
    check("gap_viol",  32'(gv),              32'd0);
    check("gap_edges", 32'(edges0 - e0),     32'd707);
    check("gap_done",  32'(done_cnt0 - d0),  32'd1);
    check("gap_chain", 32'(chain_errs(0)),   32'd0);

    // Readback with toggling out_ready.
    e0 = edges0; d0 = done_cnt0;
    readback(0, nrx, bpv);
    wait_idle("rb_idle");
    errs = 0;
    for (int k = 0; k < NW - 1; k++) if (rx_words[k] !== tx_words[k]) errs++;
    check("rb_count",  32'(nrx),             32'd89);
    check("rb_words",  32'(errs),            32'd0);
    check("rb_w0",     32'(rx_words[0]),     32'h0B);
    check("rb_w88",    32'(rx_words[88]),    32'h03);
    check("rb_bp",     32'(bpv),             32'd0);
    check("rb_edges",  32'(edges0 - e0),     32'd707);
    check("rb_done",   32'(done_cnt0 - d0),  32'd1);
    check("rb_chain",  32'(chain_errs(0)),   32'd0);

    // Reset at bit 300 of a load.
    e0 = edges0;
    pulse_start(0, 1'b0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    wt = 0;
    while ((edges0 - e0) < 300 && wt < 4 * TMO) begin @(negedge clk); wt++; end
    check("abort_bit", 32'(edges0 - e0), 32'd300);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cfg_en",    32'(cfg_en0),    32'd0);
    check("abort_busy",      32'(busy0),      32'd0);
    check("abort_in_ready",  32'(in_ready0),  32'd0);
    check("abort_out_valid", 32'(out_valid0), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NW; k++) tx_words[k] = 8'(k * 5 + 3);
    e0 = edges0; d0 = done_cnt0;
    pulse_start(0, 1'b0);
    send_words(1'b0, gv, gc);
    wait_idle("reload_idle");
    check("reload_edges", 32'(edges0 - e0),    32'd707);
    check("reload_done",  32'(done_cnt0 - d0), 32'd1);
    check("reload_chain", 32'(chain_errs(0)),  32'd0);

    // start pulsed while a load is running.
    for (int k = 0; k < NW; k++) tx_words[k] = 8'(k * 13) ^ 8'h5A;
    e0 = edges0; d0 = done_cnt0;
    pulse_start(0, 1'b0);
    fork
      send_words(1'b0, gv, gc);
      begin
        repeat (500) @(negedge clk);
        start0 = 1'b1;
        mode   = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        mode   = 1'b0;
      end
    join
    wait_idle("restart_idle");
    check("restart_edges", 32'(edges0 - e0),    32'd707);
    check("restart_done",  32'(done_cnt0 - d0), 32'd1);
    check("restart_chain", 32'(chain_errs(0)),  32'd0);

    // CLK_DIV = 1 instance.
    for (int k = 0; k < NW; k++) tx_words[k] = 8'(k * 37 + 11);
    e0 = edges1; d0 = done_cnt1; s4 = sp_bit1; s5 = sp_word1;
    pulse_start(1, 1'b0);
    send_words(1'b0, gv, gc);
    wait_idle("div1_idle");
    check("div1_edges",   32'(edges1 - e0),    32'd707);
    check("div1_done",    32'(done_cnt1 - d0), 32'd1);
    check("div1_chain",   32'(chain_errs(1)),  32'd0);
    check("div1_sp_bit",  32'(sp_bit1 - s4),   32'd618);
    check("div1_sp_word", 32'(sp_word1 - s5),  32'd88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream configuration controller for test_top.
- Accepts the bitstream as a word stream over valid/ready and serialises it onto the fabric's config_in/config_clk/config_en shift chain, bit 0 first.
- Also supports non-destructive readback: shifts the chain with config_out recirculated into config_in, and emits the captured bits as words.
- Replaces the behavioural bitstream-shifting task used in simulation, so the fabric can be configured from a host/DMA interface.

Parameters:
- CONFIG_WIDTH, 707, total bits in the fabric configuration chain.
- WORD_WIDTH, 8, width of the bitstream input/output words.
- CLK_DIV, 2, clk cycles per config_clk phase (low or high), minimum 1.
- NUM_WORDS (local), ceil(CONFIG_WIDTH/WORD_WIDTH), 89 at defaults.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- mode  input  1  0 = load, 1 = readback; sampled together with start.
- in_data  input  WORD_WIDTH  bitstream word; bit j of word k is chain bit k*WORD_WIDTH+j.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word (FETCH state only).
- out_data  output  WORD_WIDTH  readback word, same bit packing as in_data.
- out_valid  output  1  readback word valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when an operation completes.
- config_in  output  1  serial bit to the fabric chain (name matches the fabric port).
- config_clk  output  1  chain shift clock; the fabric shifts on its rising edge.
- config_en  output  1  chain shift enable.
- config_out  input  1  tail of the fabric chain.

Behaviour:
- Reset: all outputs are 0 on the edge after rst is sampled high; state returns to IDLE and counters clear.
- Reset mid-operation aborts immediately and drops config_en in the same edge. Fabric contents are then undefined and the software must reload.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, EMIT, DONE.
- IDLE:
  - start & !mode → FETCH.
  - start & mode → SHIFT_LO.
  - Bit counter and word-bit index are zeroed on exit.
- config_en is 1 in FETCH, SHIFT_LO, SHIFT_HI and EMIT, and 0 otherwise.
- FETCH:
  - in_ready = 1.
  - On in_valid & in_ready, latch the word, set bit index 0, go to SHIFT_LO.
  - config_clk holds 0 while stalled; in_valid gaps are legal.
- SHIFT_LO, CLK_DIV cycles:
  - config_clk = 0.
  - config_in = the current word bit in load mode, or config_out in readback mode.
  - config_in is registered and stable for the whole bit period.
  - In readback mode, config_out is captured into the current word-bit position on the last LO cycle.
- SHIFT_HI, CLK_DIV cycles:
  - config_clk = 1 (rising edge on entry); config_in is unchanged.
  - On exit, the bit counter increments.
- After SHIFT_HI:
  - If the bit counter equals CONFIG_WIDTH: go to DONE in load mode, or EMIT with a final partial word in readback mode.
  - Else if the word bit index equals WORD_WIDTH-1: go to FETCH in load mode, or EMIT in readback mode.
  - Else: increment the bit index and go to SHIFT_LO.
- EMIT:
  - out_valid = 1 and out_data holds the captured word; unused upper bits of the final partial word are 0.
  - Hold until out_ready. Then go to DONE if all bits have been shifted, else to SHIFT_LO with bit index 0.
  - config_clk holds 0 during backpressure.
- DONE: done = 1 for exactly one cycle, config_en = 0, then go to IDLE.
- Final partial load word: only the low CONFIG_WIDTH mod WORD_WIDTH bits are shifted; upper bits are ignored.
- start while busy is ignored. mode is held internally for the whole operation.
- Throughput: 2*CLK_DIV clk cycles per bit, plus one FETCH cycle per word when in_valid is already high.
- Readback returns words in the same order and packing as load, and leaves the chain contents unchanged (CONFIG_WIDTH recirculating shifts).

Decomposition:
- Package cfg_loader_pkg holds the state enum and the NUM_WORDS / last-word-width localparam functions.
- Sub-module cfg_phase_timer: CLK_DIV down-counter producing phase_last, reused by SHIFT_LO and SHIFT_HI.

Test Plan:
- Load 707-bit pattern 0xA5-repeat (89 words, in_valid always high, CLK_DIV=2) → behavioural chain model holds the exact pattern. config_clk period is 4 clk cycles, exactly 707 rising edges occur, config_en falls at DONE, and done pulses once.
- Load with in_valid deasserted for 7 cycles every 3rd word → identical chain contents; config_clk stays 0 and config_en stays 1 during gaps.
- Readback after load with out_ready toggling 1/0 → 89 words equal to the input. Word 88 = low 3 bits of the input word with upper 5 bits zero. The chain is unchanged afterwards.
- rst asserted at bit 300 of a load → next edge: config_en=0, busy=0, in_ready=0, out_valid=0. A subsequent full load succeeds.
- start pulsed mid-load → ignored; the bit count stays 707 and done pulses once.
- CLK_DIV=1 build → 2-cycle config_clk period; the full load completes with a correct chain.
